uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Purpose: UART receive controller. It detects the start bit, counts oversample
//   edges for the external majority sampler, shifts in the data LSB first, checks
//   the optional parity bit and the stop bit, and publishes each good word.
// Latency: data_valid is high for the one cycle after the stop bit-end edge.
//   That edge is T0 + nbits*Prescale - 1, where T0 is the start-detect edge.
// Backpressure: none. The serial line cannot be stalled, so a word must be
//   consumed during its data_valid cycle.
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   RX_IN             serial line, idle high
//   Prescale          oversampling ratio 8/16/32; any other value is used as 8
//   PAR_EN, PAR_TYP   parity present; parity type (0 even, 1 odd)
//   sampled_bit       majority-voted bit from the sampler
//   edge_cnt          oversample edge index within the bit; feeds the sampler
//   data_samp_en      sampler enable, high while a frame is in progress
//   P_DATA            last good word received
//   data_valid        one-cycle strobe for a new P_DATA
//   par_err, stp_err  error flags; each holds until the next start detect
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [5:0]            edge_cnt,
  output logic                  data_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_nxt;
  logic [5:0]              pre_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [BCW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [5:0]              pre_norm;
  logic                    bit_end;
  logic                    last_data;
  logic                    exp_par;

  // Map unsupported ratios to 8 so that edge_cnt always wraps at a power of two.
  always_comb begin
    pre_norm = 6'd8;
    case (Prescale)
      6'd16:   pre_norm = 6'd16;
      6'd32:   pre_norm = 6'd32;
      default: pre_norm = 6'd8;
    endcase
  end

  // The sampler's vote is stable on the last oversample edge of each bit.
  assign bit_end   = (state != IDLE) && (edge_cnt == pre_q - 6'd1);
  assign last_data = (bit_cnt == BCW'(DATA_WIDTH - 1));
  // shift_q holds the complete word by the time the parity bit is evaluated.
  assign exp_par   = (^shift_q) ^ par_typ_q;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    data_samp_en = (state != IDLE);
    case (state)
      IDLE:    if (!RX_IN) state_nxt = START;
      START:   if (bit_end) state_nxt = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && last_data) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt   <= '0;
      pre_q      <= 6'd8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state == IDLE) begin
        edge_cnt <= '0;
        if (!RX_IN) begin
          // The start-detect edge counts as oversample edge 0 of the start bit.
          edge_cnt  <= 6'd1;
          pre_q     <= pre_norm;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          bit_cnt   <= '0;
          par_err   <= 1'b0;
          stp_err   <= 1'b0;
        end
      end else begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      end

      if (state == DATA && bit_end) begin
        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == PARITY && bit_end)
        par_err <= (sampled_bit != exp_par);

      if (state == STOP && bit_end) begin
        stp_err <= !sampled_bit;
        // par_err already holds this frame's result; it is zero when there is no parity bit.
        if (sampled_bit && !par_err) begin
          P_DATA     <= shift_q;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule
